// File: rtl/div_sequencer.sv
// Multi-cycle restoring radix-2 divider for the M-extension DIV/DIVU/REM/REMU ops.
// Define DIV_SEQUENCER_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module div_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [31:0] rem_reg, rem_next;
    logic [31:0] quo_reg, quo_next;
    logic [31:0] divisor_reg, divisor_next;
    logic        is_rem_reg, is_rem_next;
    logic        neg_q_reg, neg_q_next;
    logic        neg_r_reg, neg_r_next;
    logic        div_zero_reg, div_zero_next;
    logic [31:0] result_reg, result_next;

    logic        accept;
    logic        is_signed;
    logic        rs1_neg;
    logic        rs2_neg;
    logic        rs2_zero;
    logic [31:0] rs1_abs;
    logic [31:0] rs2_abs;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        step_ok;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;

    // Operand preparation for the request currently on the inputs
    assign is_signed = ~func3[0];
    assign rs1_neg   = is_signed & rs1[31];
    assign rs2_neg   = is_signed & rs2[31];
    assign rs2_zero  = (rs2 == 32'd0);
    assign rs1_abs   = rs1_neg ? (32'd0 - rs1) : rs1;
    assign rs2_abs   = rs2_neg ? (32'd0 - rs2) : rs2;

    // rst_n gating keeps stall low while reset is held
    assign accept = rst_n & start & func3[2] & ~flush &
                    ((state_reg == IDLE) || (state_reg == DONE));

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    assign rem_shift = {rem_reg, quo_reg[31]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};
    assign step_ok   = ~rem_diff[32];

    // A zero divisor yields all-ones magnitude; forcing it avoids the sign fix flipping it
    assign quo_fix    = div_zero_reg ? 32'hFFFF_FFFF :
                        (neg_q_reg ? (32'd0 - quo_reg) : quo_reg);
    assign rem_fix    = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
    assign fix_result = is_rem_reg ? rem_fix : quo_fix;

`ifdef DIV_SEQUENCER_EARLY_OUT_EN
    logic        ovf_op;
    logic        special_op;
    logic [31:0] special_result;

    assign ovf_op         = is_signed & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    assign special_op     = rs2_zero | ovf_op;
    assign special_result = func3[1] ? (rs2_zero ? rs1 : 32'd0)
                                     : (rs2_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        rem_next      = rem_reg;
        quo_next      = quo_reg;
        divisor_next  = divisor_reg;
        is_rem_next   = is_rem_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        div_zero_next = div_zero_reg;
        result_next   = result_reg;

        case (state_reg)
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    rem_next   = step_ok ? rem_diff[31:0] : rem_shift[31:0];
                    quo_next   = {quo_reg[30:0], step_ok};
                    count_next = count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        state_next = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    result_next = fix_result;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Acceptance overrides the DONE->IDLE return so ops can run back to back
        if (accept) begin
            state_next    = CALC;
            count_next    = 5'd0;
            rem_next      = 32'd0;
            quo_next      = rs1_abs;
            divisor_next  = rs2_abs;
            is_rem_next   = func3[1];
            neg_q_next    = rs1_neg ^ rs2_neg;
            neg_r_next    = rs1_neg;
            div_zero_next = rs2_zero;
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
            if (special_op) begin
                state_next  = DONE;
                result_next = special_result;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= 5'd0;
            rem_reg      <= 32'd0;
            quo_reg      <= 32'd0;
            divisor_reg  <= 32'd0;
            is_rem_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            result_reg   <= 32'd0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            rem_reg      <= rem_next;
            quo_reg      <= quo_next;
            divisor_reg  <= divisor_next;
            is_rem_reg   <= is_rem_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            div_zero_reg <= div_zero_next;
            result_reg   <= result_next;
        end
    end

    assign busy   = (state_reg == CALC) || (state_reg == FIX);
    assign done   = (state_reg == DONE);
    assign stall  = accept || busy;
    assign result = result_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_div_sequencer;

`ifdef DIV_SEQUENCER_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int NORM_LAT = 34;
    localparam int SPEC_LAT = EARLY ? 1 : 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    div_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic for the four ops, straight from the ISA definition
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!f3[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: cycles remaining until done, the pending answer, and the visible outputs
    int          m_cnt = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_pending = 32'd0;
    logic [31:0] m_result = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    = 0;
            m_done   = 1'b0;
            m_result = 32'd0;
        end else if (flush) begin
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
            if (m_done) m_result = m_pending;
        end else if (start && func3[2]) begin
            m_pending = ref_result(func3, rs1, rs2);
            m_cnt     = ((EARLY && is_special(func3, rs1, rs2)) ? 1 : NORM_LAT) - 1;
            m_done    = (m_cnt == 0);
            if (m_done) m_result = m_pending;
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit exp_stall;
        exp_stall = rst_n && (m_cnt > 0 || (start && func3[2] && !flush && m_cnt == 0));
        check32("busy", {31'd0, busy}, {31'd0, m_cnt > 0});
        check32("done", {31'd0, done}, {31'd0, m_done});
        check32("stall", {31'd0, stall}, {31'd0, exp_stall});
        check32("result", result, m_result);
    end

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input bit immediate);
        int cyc;
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        func3 = f3;
        rs1   = a;
        rs2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end
        check32({name, " result"}, result, exp_res);
        check32({name, " latency"}, cyc, exp_lat);
        $display("op %s rs1=%h rs2=%h result=%h cycles=%0d", name, a, b, result, cyc);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset busy", {31'd0, busy}, 32'd0);
        check32("reset done", {31'd0, done}, 32'd0);
        check32("reset stall", {31'd0, stall}, 32'd0);
        check32("reset result", result, 32'd0);
        rst_n = 1'b1;

        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0);
        run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b0);
        run_op("DIV -100/7", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 1'b0);
        run_op("REM -100/7", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 1'b0);
        run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 1'b0);
        run_op("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5, SPEC_LAT, 1'b0);
        run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 1'b0);
        run_op("REMU 5/0", 3'b111, 32'd5, 32'd0, 32'd5, SPEC_LAT, 1'b0);
        run_op("DIV -7/0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 1'b0);
        run_op("REM -7/0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPEC_LAT, 1'b0);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, 1'b0);
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT, 1'b0);
        run_op("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("REM 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);
        run_op("DIVU max/1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b0);

        // Back-to-back: second start held during the DONE cycle of the first
        run_op("b2b DIVU 1000/10", 3'b101, 32'd1000, 32'd10, 32'd100, 34, 1'b1);
        run_op("b2b REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT, 1'b1);

        // Starts that must be ignored: non-divide func3, and start together with flush
        @(posedge clk);
        #1;
        start = 1'b1; func3 = 3'b001; rs1 = 32'd9; rs2 = 32'd3;
        @(posedge clk);
        #1;
        check32("ignored func3 busy", {31'd0, busy}, 32'd0);
        start = 1'b1; func3 = 3'b101; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check32("flush-priority busy", {31'd0, busy}, 32'd0);
        $display("op ignored starts checked");

        // Flush during the tenth CALC cycle
        start = 1'b1; func3 = 3'b101; rs1 = 32'd50; rs2 = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check32("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check32("post-flush busy", {31'd0, busy}, 32'd0);
        check32("post-flush stall", {31'd0, stall}, 32'd0);
        check32("post-flush done", {31'd0, done}, 32'd0);
        check32("post-flush result", result, 32'd0);
        $display("op flush at CALC cycle 10 checked");
        @(posedge clk);
        #1;
        run_op("after flush DIVU 50/5", 3'b101, 32'd50, 32'd5, 32'd10, 34, 1'b1);

        // Asynchronous reset in the middle of CALC
        run_op("pre-reset REMU 23/5", 3'b111, 32'd23, 32'd5, 32'd3, 34, 1'b0);
        start = 1'b1; func3 = 3'b100; rs1 = 32'd77; rs2 = 32'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("mid reset busy", {31'd0, busy}, 32'd0);
        check32("mid reset done", {31'd0, done}, 32'd0);
        check32("mid reset stall", {31'd0, stall}, 32'd0);
        check32("mid reset result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check32("after reset done", {31'd0, done}, 32'd0);
        $display("op mid-CALC reset checked");

        run_op("final DIV -100/7", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 1'b0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
